// File: rtl/systolic_mem_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_mem_sequencer_pkg
//  Description : Shared state encoding, counter sizing and lane slice helpers
//                for the systolic array memory sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package systolic_mem_sequencer_pkg;

    // Sequencer FSM encoding
    localparam int         c_STATE_W = 2;
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    // Cycle counter width: skewed runs last up to 2*width_height-1 cycles
    function automatic int cnt_width(input int width_height);
        return $clog2(2 * width_height);
    endfunction

    // Bit offset of lane c inside the flattened address bus
    function automatic int lane_lsb(input int lane, input int addr_width);
        return lane * addr_width;
    endfunction

endpackage : systolic_mem_sequencer_pkg
`default_nettype wire

// File: rtl/systolic_mem_sequencer_skew_lane_chain.sv
`default_nettype none
// ============================================================================
//  Module      : skew_lane_chain
//  Description : Per-lane {en, addr} register chain. Lane 0 always takes the
//                source; in skew mode each lane takes its left neighbour one
//                cycle later, otherwise the source is broadcast to all lanes.
//                Lanes beyond the active column count are forced off.
//  Revision    : 1.0 - initial release
// ============================================================================
module skew_lane_chain
    import systolic_mem_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH   = 8,
    parameter int WIDTH_HEIGHT = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               clear,
    input  logic                               skew,
    input  logic [$clog2(WIDTH_HEIGHT)-1:0]    num_col,
    input  logic                               src_en,
    input  logic [ADDR_WIDTH-1:0]              src_addr,
    output logic [WIDTH_HEIGHT-1:0]            out_en,
    output logic [ADDR_WIDTH*WIDTH_HEIGHT-1:0] out_addr
);

    logic [WIDTH_HEIGHT-1:0] r_en;
    logic [ADDR_WIDTH-1:0]   r_addr [WIDTH_HEIGHT];
    logic [WIDTH_HEIGHT-1:0] w_in_en;
    logic [ADDR_WIDTH-1:0]   w_in_addr [WIDTH_HEIGHT];
    logic [WIDTH_HEIGHT-1:0] w_on;

    // Select each lane's input (neighbour or broadcast) and apply column mask
    always_comb begin
        w_in_en[0]   = src_en;
        w_in_addr[0] = src_addr;
        for (int c = 1; c < WIDTH_HEIGHT; c++) begin
            w_in_en[c]   = skew ? r_en[c-1]   : src_en;
            w_in_addr[c] = skew ? r_addr[c-1] : src_addr;
        end
        for (int c = 0; c < WIDTH_HEIGHT; c++) begin
            w_on[c] = w_in_en[c] && (c <= int'(num_col));
        end
    end

    // Lane registers; disabled lanes hold address zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_en <= '0;
            for (int c = 0; c < WIDTH_HEIGHT; c++) begin
                r_addr[c] <= '0;
            end
        end else if (clear) begin
            r_en <= '0;
            for (int c = 0; c < WIDTH_HEIGHT; c++) begin
                r_addr[c] <= '0;
            end
        end else begin
            r_en <= w_on;
            for (int c = 0; c < WIDTH_HEIGHT; c++) begin
                r_addr[c] <= w_on[c] ? w_in_addr[c] : '0;
            end
        end
    end

    assign out_en = r_en;

    // Flatten the lane addresses onto the output bus
    generate
        for (genvar c = 0; c < WIDTH_HEIGHT; c++) begin : g_pack
            assign out_addr[lane_lsb(c, ADDR_WIDTH) +: ADDR_WIDTH] = r_addr[c];
        end
    endgenerate

endmodule : skew_lane_chain
`default_nettype wire

// File: rtl/systolic_mem_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_mem_sequencer
//  Description : Generates per-column buffer addresses and read enables for a
//                systolic array from a row-major buffer, with start/busy/done
//                handshake, programmable row stride and optional diagonal skew.
//  Revision    : 1.0 - initial release
// ============================================================================
module systolic_mem_sequencer
    import systolic_mem_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH   = 8,
    parameter int WIDTH_HEIGHT = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic                               skew,
    input  logic [ADDR_WIDTH-1:0]              base_addr,
    input  logic [ADDR_WIDTH-1:0]              stride,
    input  logic [$clog2(WIDTH_HEIGHT)-1:0]    num_row,
    input  logic [$clog2(WIDTH_HEIGHT)-1:0]    num_col,
    output logic                               busy,
    output logic [ADDR_WIDTH*WIDTH_HEIGHT-1:0] out_addr,
    output logic [WIDTH_HEIGHT-1:0]            out_en,
    output logic                               done
);

    localparam int c_NW = $clog2(WIDTH_HEIGHT);
    localparam int c_CW = cnt_width(WIDTH_HEIGHT);

    logic [c_STATE_W-1:0]  r_state;
    logic                  r_skew;
    logic [ADDR_WIDTH-1:0] r_stride;
    logic [c_NW-1:0]       r_num_row;
    logic [c_NW-1:0]       r_num_col;
    logic [c_CW-1:0]       r_t;
    logic [ADDR_WIDTH-1:0] r_row;

    logic [c_STATE_W-1:0]  w_nxt_state;
    logic                  w_load;
    logic                  w_last;
    logic [c_CW-1:0]       w_t_inc;
    logic [c_CW-1:0]       w_t_end;
    logic [ADDR_WIDTH-1:0] w_row_inc;
    logic                  w_src_en;
    logic [ADDR_WIDTH-1:0] w_src_addr;
    logic                  w_mode;
    logic [c_NW-1:0]       w_mask;
    logic                  w_clear;

    // Next state plus the lane-0 value the chain must show next cycle
    always_comb begin
        w_nxt_state = r_state;
        w_load      = 1'b0;
        w_src_en    = 1'b0;
        w_src_addr  = '0;
        w_mode      = r_skew;
        w_mask      = r_num_col;
        w_clear     = 1'b1;
        w_t_inc     = r_t + c_CW'(1);
        w_row_inc   = r_row + r_stride;
        w_t_end     = r_skew ? (c_CW'(r_num_row) + c_CW'(r_num_col))
                             : c_CW'(r_num_row);
        w_last      = (r_t == w_t_end);
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    // Row 0 goes out in the first RUN cycle, using fresh inputs
                    w_nxt_state = c_ST_RUN;
                    w_load      = 1'b1;
                    w_src_en    = 1'b1;
                    w_src_addr  = base_addr;
                    w_mode      = skew;
                    w_mask      = num_col;
                    w_clear     = 1'b0;
                end
            end
            c_ST_RUN: begin
                if (w_last) begin
                    w_nxt_state = c_ST_DONE;
                end else begin
                    // Lane 0 runs out of rows before the skewed tail drains
                    w_clear    = 1'b0;
                    w_src_en   = (w_t_inc <= c_CW'(r_num_row));
                    w_src_addr = w_src_en ? w_row_inc : '0;
                end
            end
            c_ST_DONE: begin
                w_nxt_state = c_ST_IDLE;
            end
            default: begin
                w_nxt_state = c_ST_IDLE;
            end
        endcase
    end

    // Sequencer FSM: latches the job on start, walks rows, registers busy/done
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_ST_IDLE;
            r_skew    <= 1'b0;
            r_stride  <= '0;
            r_num_row <= '0;
            r_num_col <= '0;
            r_t       <= '0;
            r_row     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            busy    <= (w_nxt_state != c_ST_IDLE);
            done    <= (w_nxt_state == c_ST_DONE);
            if (w_load) begin
                r_skew    <= skew;
                r_stride  <= stride;
                r_num_row <= num_row;
                r_num_col <= num_col;
                r_t       <= '0;
                r_row     <= base_addr;
            end else if (r_state == c_ST_RUN) begin
                r_t   <= w_t_inc;
                r_row <= w_row_inc;
            end
        end
    end

    skew_lane_chain #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .WIDTH_HEIGHT (WIDTH_HEIGHT)
    ) u_chain (
        .clk      (clk),
        .reset    (reset),
        .clear    (w_clear),
        .skew     (w_mode),
        .num_col  (w_mask),
        .src_en   (w_src_en),
        .src_addr (w_src_addr),
        .out_en   (out_en),
        .out_addr (out_addr)
    );

endmodule : systolic_mem_sequencer
`default_nettype wire

// File: tb/tb_systolic_mem_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_systolic_mem_sequencer
//  Description : Directed scoreboard bench for systolic_mem_sequencer with a
//                4-column, 8-bit address configuration.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_mem_sequencer;

    localparam int c_aw = 8;
    localparam int c_wh = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        skew;
    logic [7:0]  base_addr;
    logic [7:0]  stride;
    logic [1:0]  num_row;
    logic [1:0]  num_col;
    logic        busy;
    logic [31:0] out_addr;
    logic [3:0]  out_en;
    logic        done;

    typedef struct {
        logic [3:0]  en;
        logic [31:0] addr;
        logic        busy;
        logic        done;
    } exp_t;

    exp_t r_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    systolic_mem_sequencer #(
        .ADDR_WIDTH   (c_aw),
        .WIDTH_HEIGHT (c_wh)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .skew      (skew),
        .base_addr (base_addr),
        .stride    (stride),
        .num_row   (num_row),
        .num_col   (num_col),
        .busy      (busy),
        .out_addr  (out_addr),
        .out_en    (out_en),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: expected outputs for every cycle after the start cycle
    function automatic int push_xfer(input int sk, input int base, input int strd,
                                     input int nr, input int nc);
        int   len;
        exp_t e;
        len = sk ? (nr + nc + 1) : (nr + 1);
        for (int t = 0; t < len; t++) begin
            e.en   = '0;
            e.addr = '0;
            e.busy = 1'b1;
            e.done = 1'b0;
            for (int c = 0; c < c_wh; c++) begin
                bit on;
                int row;
                on  = (c <= nc) && (sk == 0 || (c <= t && t <= c + nr));
                row = sk ? (t - c) : t;
                if (on) begin
                    e.en[c]              = 1'b1;
                    e.addr[c*c_aw +: c_aw] = 8'(base + row * strd);
                end
            end
            r_q.push_back(e);
        end
        e.en = '0; e.addr = '0; e.busy = 1'b1; e.done = 1'b1;
        r_q.push_back(e);
        e.busy = 1'b0; e.done = 1'b0;
        r_q.push_back(e);
        r_q.push_back(e);
        return len;
    endfunction

    task automatic check_cycle(input string tag);
        exp_t e;
        if (r_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s: scoreboard empty, observed en 0x%0h expected an entry", tag, out_en);
        end else begin
            e = r_q.pop_front();
            chk({tag, " en"},   {28'd0, out_en}, {28'd0, e.en});
            chk({tag, " addr"}, out_addr, e.addr);
            chk({tag, " busy"}, {31'd0, busy}, {31'd0, e.busy});
            chk({tag, " done"}, {31'd0, done}, {31'd0, e.done});
        end
    endtask

    // One complete transfer; poke re-pulses start at cycle 2 and the done cycle
    task automatic run_xfer(input string name, input int sk, input int base,
                            input int strd, input int nr, input int nc, input bit poke);
        int len;
        len = push_xfer(sk, base, strd, nr, nc);
        @(negedge clk);
        skew      = sk[0];
        base_addr = 8'(base);
        stride    = 8'(strd);
        num_row   = 2'(nr);
        num_col   = 2'(nc);
        start     = 1'b1;
        for (int k = 1; k <= len + 3; k++) begin
            @(negedge clk);
            check_cycle($sformatf("%s c%0d", name, k));
            start = poke && (k == 2 || k == len + 1);
            if (poke) base_addr = 8'h80;
        end
        start = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        skew      = 1'b0;
        base_addr = '0;
        stride    = '0;
        num_row   = '0;
        num_col   = '0;
        #1;
        chk("reset en",   {28'd0, out_en}, 32'd0);
        chk("reset addr", out_addr, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        run_xfer("aligned", 0, 'h10, 1, 2, 1, 1'b0);
        run_xfer("skew",    1, 'h20, 2, 1, 2, 1'b0);
        run_xfer("wrap",    0, 'hFE, 1, 3, 0, 1'b0);
        run_xfer("protect", 0, 'h10, 1, 2, 1, 1'b1);
        run_xfer("single",  1, 'h55, 7, 0, 0, 1'b0);

        // Asynchronous reset in the middle of a skewed transfer
        void'(push_xfer(1, 'h40, 3, 3, 3));
        @(negedge clk);
        skew = 1'b1; base_addr = 8'h40; stride = 8'd3; num_row = 2'd3; num_col = 2'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_cycle("abort c1");
        @(negedge clk);
        check_cycle("abort c2");
        r_q.delete();
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort en",   {28'd0, out_en}, 32'd0);
        chk("abort addr", out_addr, 32'd0);
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort done", {31'd0, done}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("post-abort busy %0d", k), {31'd0, busy}, 32'd0);
            chk($sformatf("post-abort done %0d", k), {31'd0, done}, 32'd0);
            chk($sformatf("post-abort en %0d", k),   {28'd0, out_en}, 32'd0);
        end
        run_xfer("rerun", 1, 'h40, 3, 3, 3, 1'b0);

        run_xfer("full", 1, 'h00, 4, 3, 3, 1'b0);

        chk("scoreboard drained", r_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule : tb_systolic_mem_sequencer
`default_nettype wire
